// File: rtl/imm_gen_pkg.sv
// Shared opcode constants and immediate-format encoding for the pipelined
// immediate generator and its combinational decoder.
package imm_gen_pkg;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_FENCE   = 7'b0001111;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } imm_fmt_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / immediate-out stream bundle. master drives instructions
// and consumes results; slave is the immediate generator stage.
interface imm_gen_pipe_if
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  imm_fmt_t         out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

endinterface

// File: rtl/imm_decode_xlen.sv
// Combinational RISC-V immediate decoder: builds a 32-bit sign-extended
// immediate per format, then widens it to XLEN (32 or 64).
module imm_decode_xlen
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_t        fmt,
  output logic            illegal
);

  logic [31:0] raw;
  logic        is64;

  assign is64 = (XLEN == 64);

  always_comb begin
    raw     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (instr[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
        fmt = FMT_I;
        raw = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_OPIMM32: begin
        if (is64) begin
          fmt = FMT_I;
          raw = {{20{instr[31]}}, instr[31:20]};
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        fmt = FMT_S;
        raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt = FMT_U;
        raw = {instr[31:12], 12'h000};
      end
      OPC_JAL: begin
        fmt = FMT_J;
        raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_SYSTEM: begin
        // funct3[2] selects the CSR immediate forms, whose rs1 field is a zimm
        if (instr[14]) begin
          fmt = FMT_Z;
          raw = {27'd0, instr[19:15]};
        end else begin
          fmt = FMT_I;
          raw = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OPC_OP, OPC_FENCE: begin
        fmt = FMT_NONE;
      end
      OPC_OP32: begin
        illegal = !is64;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // raw is already sign-extended to 32 bits; zimm has bit 31 clear so it widens as zero
  assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with an output register plus one skid entry.
// Optional IMM_GEN_STATS_EN adds saturating accept/illegal counters.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  imm_gen_pipe_if.slave bus
`ifdef IMM_GEN_STATS_EN
  ,
  output logic [31:0] stat_acc_cnt,
  output logic [31:0] stat_ill_cnt
`endif
);

  logic [XLEN-1:0]  dec_imm;
  imm_fmt_t         dec_fmt;
  logic             dec_ill;

  logic             out_valid_r;
  logic [XLEN-1:0]  out_imm_r;
  imm_fmt_t         out_fmt_r;
  logic             out_ill_r;
  logic [TAG_W-1:0] out_tag_r;

  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  imm_fmt_t         skid_fmt;
  logic             skid_ill;
  logic [TAG_W-1:0] skid_tag;

  logic             accept;
  logic             drain;

  imm_decode_xlen #(.XLEN(XLEN)) u_decode (
    .instr   (bus.in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_ill)
  );

  // in_ready comes straight from the skid flop, so out_ready never reaches it combinationally
  assign bus.in_ready    = !skid_valid;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_imm     = out_imm_r;
  assign bus.out_fmt     = out_fmt_r;
  assign bus.out_illegal = out_ill_r;
  assign bus.out_tag     = out_tag_r;

  assign accept = bus.in_valid && !skid_valid;
  assign drain  = out_valid_r && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_imm_r   <= '0;
      out_fmt_r   <= FMT_NONE;
      out_ill_r   <= 1'b0;
      out_tag_r   <= '0;
      skid_valid  <= 1'b0;
      skid_imm    <= '0;
      skid_fmt    <= FMT_NONE;
      skid_ill    <= 1'b0;
      skid_tag    <= '0;
    end else if (!out_valid_r || drain) begin
      // output slot is free this cycle: refill from skid first, else from the decoder
      if (skid_valid) begin
        out_valid_r <= 1'b1;
        out_imm_r   <= skid_imm;
        out_fmt_r   <= skid_fmt;
        out_ill_r   <= skid_ill;
        out_tag_r   <= skid_tag;
        skid_valid  <= accept;
        if (accept) begin
          skid_imm <= dec_imm;
          skid_fmt <= dec_fmt;
          skid_ill <= dec_ill;
          skid_tag <= bus.in_tag;
        end
      end else if (accept) begin
        out_valid_r <= 1'b1;
        out_imm_r   <= dec_imm;
        out_fmt_r   <= dec_fmt;
        out_ill_r   <= dec_ill;
        out_tag_r   <= bus.in_tag;
      end else begin
        out_valid_r <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_imm   <= dec_imm;
      skid_fmt   <= dec_fmt;
      skid_ill   <= dec_ill;
      skid_tag   <= bus.in_tag;
    end
  end

`ifdef IMM_GEN_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_acc_cnt <= '0;
      stat_ill_cnt <= '0;
    end else if (accept) begin
      if (stat_acc_cnt != 32'hFFFF_FFFF) stat_acc_cnt <= stat_acc_cnt + 32'd1;
      if (dec_ill && stat_ill_cnt != 32'hFFFF_FFFF) stat_ill_cnt <= stat_ill_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances, directed,
// backpressure, reset-mid-stream and random streams. Build with IMM_GEN_STATS_EN for counters.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [7:0]  tag;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   chk_cnt;
  exp_t sb [$];

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) bus32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(8)) bus64 ();

`ifdef IMM_GEN_STATS_EN
  logic [31:0] acc32, ill32, acc64, ill64;
`endif

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
`ifdef IMM_GEN_STATS_EN
    , .stat_acc_cnt (acc32), .stat_ill_cnt (ill32)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk (clk),
    .rst (rst),
    .bus (bus64)
`ifdef IMM_GEN_STATS_EN
    , .stat_acc_cnt (acc64), .stat_ill_cnt (ill64)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decoder written from the instruction-set encodings
  function automatic void model(input logic [31:0] ins, input bit is64,
                                output logic [63:0] imm, output logic [2:0] fmt,
                                output logic ill);
    longint v;
    v = 0; fmt = 3'd0; ill = 1'b0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: begin fmt = 3'd1; v = $signed(ins[31:20]); end
      7'h1B: if (is64) begin fmt = 3'd1; v = $signed(ins[31:20]); end else ill = 1'b1;
      7'h23: begin fmt = 3'd2; v = $signed({ins[31:25], ins[11:7]}); end
      7'h63: begin fmt = 3'd3; v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); end
      7'h37, 7'h17: begin fmt = 3'd4; v = $signed({ins[31:12], 12'h000}); end
      7'h6F: begin fmt = 3'd5; v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); end
      7'h73: if (ins[14]) begin fmt = 3'd6; v = longint'(ins[19:15]); end
             else begin fmt = 3'd1; v = $signed(ins[31:20]); end
      7'h33, 7'h0F: ;
      7'h3B: ill = !is64;
      default: ill = 1'b1;
    endcase
    imm = is64 ? 64'(v) : {32'd0, v[31:0]};
  endfunction

  task automatic applyStimulus(input logic valid, input logic [31:0] ins, input logic [7:0] tag);
    bus32.in_valid = valid;
    bus32.in_instr = ins;
    bus32.in_tag   = tag;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus32.in_valid = 0; bus32.in_instr = '0; bus32.in_tag = '0; bus32.out_ready = 0;
    bus64.in_valid = 0; bus64.in_instr = '0; bus64.in_tag = '0; bus64.out_ready = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({bus32.out_valid, bus32.in_ready, bus32.out_imm, bus32.out_fmt, bus32.out_illegal, bus32.out_tag}
        !== {1'b0, 1'b1, 32'd0, 3'd0, 1'b0, 8'd0})
      $display("[TB] FAIL reset32: got valid=%b ready=%b imm=%h fmt=%0d ill=%b tag=%h, want 0 1 0 0 0 0",
               bus32.out_valid, bus32.in_ready, bus32.out_imm, bus32.out_fmt, bus32.out_illegal, bus32.out_tag);
    else pass_cnt++;
    chk_cnt++;
    if ({bus64.out_valid, bus64.in_ready, bus64.out_imm, bus64.out_fmt, bus64.out_illegal, bus64.out_tag}
        !== {1'b0, 1'b1, 64'd0, 3'd0, 1'b0, 8'd0})
      $display("[TB] FAIL reset64: got valid=%b ready=%b imm=%h, want 0 1 0",
               bus64.out_valid, bus64.in_ready, bus64.out_imm);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [31:0] ins  [9] = '{32'hFFF00093, 32'hFE000EE3, 32'h123450B7, 32'h300FD073, 32'h0000007F,
                              32'h0000000F, 32'h0000003B, 32'hFFDFF0EF, 32'hFE20AC23};
    logic [31:0] eimm [9] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'h0000001F, 32'h0,
                              32'h0, 32'h0, 32'hFFFFFFFC, 32'hFFFFFFF8};
    logic [2:0]  efmt [9] = '{3'd1, 3'd3, 3'd4, 3'd6, 3'd0, 3'd0, 3'd0, 3'd5, 3'd2};
    logic        eill [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int idx = 0;
    int cyc = 0;
    exp_t e;
    sb.delete();
    bus32.out_ready = 1'b1;
    while ((idx < 9 || sb.size() != 0) && cyc < 60) begin
      if (idx < 9) applyStimulus(1'b1, ins[idx], (idx == 0) ? 8'h5A : 8'(idx * 17));
      else applyStimulus(1'b0, 32'd0, 8'd0);
      @(negedge clk);
      if (bus32.out_valid && bus32.out_ready) begin
        chk_cnt++;
        if (sb.size() == 0) $display("[TB] FAIL directed: unexpected output imm=%h", bus32.out_imm);
        else begin
          e = sb.pop_front();
          if ({bus32.out_imm, bus32.out_fmt, bus32.out_illegal, bus32.out_tag, cyc - e.cyc}
              !== {e.imm[31:0], e.fmt, e.ill, e.tag, 32'd1})
            $display("[TB] FAIL directed: got imm=%h fmt=%0d ill=%b tag=%h lat=%0d, want imm=%h fmt=%0d ill=%b tag=%h lat=1",
                     bus32.out_imm, bus32.out_fmt, bus32.out_illegal, bus32.out_tag, cyc - e.cyc,
                     e.imm[31:0], e.fmt, e.ill, e.tag);
          else pass_cnt++;
        end
      end
      if (bus32.in_valid && bus32.in_ready) begin
        e.imm = {32'd0, eimm[idx]}; e.fmt = efmt[idx]; e.ill = eill[idx];
        e.tag = bus32.in_tag; e.cyc = cyc;
        sb.push_back(e);
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    applyStimulus(1'b0, 32'd0, 8'd0);
    if (cyc >= 60) begin chk_cnt++; $display("[TB] FAIL directed_timeout: got %0d pending, want 0", sb.size()); end
  endtask

  task automatic test_xlen64;
    logic [31:0] ins  [4] = '{32'h800000B7, 32'hFFF0001B, 32'h0000003B, 32'hFFF00093};
    logic [63:0] eimm [4] = '{64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'hFFFFFFFFFFFFFFFF};
    logic [2:0]  efmt [4] = '{3'd4, 3'd1, 3'd0, 3'd1};
    int idx = 0;
    int cyc = 0;
    exp_t e;
    sb.delete();
    bus64.out_ready = 1'b1;
    while ((idx < 4 || sb.size() != 0) && cyc < 40) begin
      bus64.in_valid = (idx < 4);
      bus64.in_instr = (idx < 4) ? ins[idx] : 32'd0;
      bus64.in_tag   = 8'(8'hC0 + idx);
      @(negedge clk);
      if (bus64.out_valid && bus64.out_ready) begin
        chk_cnt++;
        if (sb.size() == 0) $display("[TB] FAIL xlen64: unexpected output imm=%h", bus64.out_imm);
        else begin
          e = sb.pop_front();
          if ({bus64.out_imm, bus64.out_fmt, bus64.out_illegal, bus64.out_tag} !== {e.imm, e.fmt, e.ill, e.tag})
            $display("[TB] FAIL xlen64: got imm=%h fmt=%0d ill=%b tag=%h, want imm=%h fmt=%0d ill=%b tag=%h",
                     bus64.out_imm, bus64.out_fmt, bus64.out_illegal, bus64.out_tag, e.imm, e.fmt, e.ill, e.tag);
          else pass_cnt++;
        end
      end
      if (bus64.in_valid && bus64.in_ready) begin
        e.imm = eimm[idx]; e.fmt = efmt[idx]; e.ill = 1'b0; e.tag = bus64.in_tag; e.cyc = cyc;
        sb.push_back(e);
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus64.in_valid = 1'b0;
    if (cyc >= 40) begin chk_cnt++; $display("[TB] FAIL xlen64_timeout: got %0d pending, want 0", sb.size()); end
  endtask

  task automatic test_backpressure;
    logic [31:0] ins [4] = '{32'h00A00513, 32'hFE20AC23, 32'hFFDFF0EF, 32'h800002B7};
    int idx = 0, cyc = 0, stall = 0, outs = 0;
    bit first = 1'b0, saw_block = 1'b0, have_snap = 1'b0;
    logic [31:0] s_imm; logic [2:0] s_fmt; logic s_ill; logic [7:0] s_tag;
    exp_t e;
    sb.delete();
    while ((idx < 4 || sb.size() != 0) && cyc < 40) begin
      bus32.out_ready = (stall == 0);
      if (stall > 0) stall--;
      if (idx < 4) applyStimulus(1'b1, ins[idx], 8'(8'h30 + idx));
      else applyStimulus(1'b0, 32'd0, 8'd0);
      @(negedge clk);
      if (have_snap) begin
        chk_cnt++;
        if ({bus32.out_valid, bus32.out_imm, bus32.out_fmt, bus32.out_illegal, bus32.out_tag}
            !== {1'b1, s_imm, s_fmt, s_ill, s_tag})
          $display("[TB] FAIL stall_stable: got valid=%b imm=%h tag=%h, want valid=1 imm=%h tag=%h",
                   bus32.out_valid, bus32.out_imm, bus32.out_tag, s_imm, s_tag);
        else pass_cnt++;
      end
      have_snap = bus32.out_valid && !bus32.out_ready;
      s_imm = bus32.out_imm; s_fmt = bus32.out_fmt; s_ill = bus32.out_illegal; s_tag = bus32.out_tag;
      if (bus32.in_valid && !bus32.in_ready) saw_block = 1'b1;
      if (bus32.out_valid && bus32.out_ready) begin
        chk_cnt++; outs++;
        if (sb.size() == 0) $display("[TB] FAIL backpressure: unexpected output tag=%h", bus32.out_tag);
        else begin
          e = sb.pop_front();
          if ({bus32.out_imm, bus32.out_fmt, bus32.out_illegal, bus32.out_tag} !== {e.imm[31:0], e.fmt, e.ill, e.tag})
            $display("[TB] FAIL backpressure: got imm=%h fmt=%0d tag=%h, want imm=%h fmt=%0d tag=%h",
                     bus32.out_imm, bus32.out_fmt, bus32.out_tag, e.imm[31:0], e.fmt, e.tag);
          else pass_cnt++;
        end
        if (!first) begin first = 1'b1; stall = 3; end
      end
      if (bus32.in_valid && bus32.in_ready) begin
        model(bus32.in_instr, 1'b0, e.imm, e.fmt, e.ill);
        e.tag = bus32.in_tag; e.cyc = cyc;
        sb.push_back(e);
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    applyStimulus(1'b0, 32'd0, 8'd0);
    bus32.out_ready = 1'b1;
    if (cyc >= 40) begin chk_cnt++; $display("[TB] FAIL backpressure_timeout: got %0d pending, want 0", sb.size()); end
    chk_cnt++;
    if (saw_block !== 1'b1) $display("[TB] FAIL in_ready_block: got saw_block=%b, want 1", saw_block);
    else pass_cnt++;
    chk_cnt++;
    if (outs !== 4) $display("[TB] FAIL output_count: got %0d, want 4", outs);
    else pass_cnt++;
  endtask

  task automatic test_reset_midstream;
    int stale = 0;
    sb.delete();
    bus32.out_ready = 1'b0;
    applyStimulus(1'b1, 32'hFFF00093, 8'h11);
    @(posedge clk); #1;
    applyStimulus(1'b1, 32'h123450B7, 8'h22);
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'd0, 8'd0);
    @(negedge clk);
    chk_cnt++;
    if ({bus32.out_valid, bus32.in_ready} !== 2'b10)
      $display("[TB] FAIL both_full: got valid=%b ready=%b, want valid=1 ready=0", bus32.out_valid, bus32.in_ready);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    chk_cnt++;
    if ({bus32.out_valid, bus32.in_ready} !== 2'b01)
      $display("[TB] FAIL async_clear: got valid=%b ready=%b, want valid=0 ready=1", bus32.out_valid, bus32.in_ready);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    bus32.out_ready = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if ({bus32.out_valid, bus32.in_ready, bus32.out_imm, bus32.out_tag} !== {1'b0, 1'b1, 32'd0, 8'd0})
      $display("[TB] FAIL post_reset: got valid=%b ready=%b imm=%h tag=%h, want 0 1 0 0",
               bus32.out_valid, bus32.in_ready, bus32.out_imm, bus32.out_tag);
    else pass_cnt++;
    repeat (4) begin
      @(negedge clk);
      if (bus32.out_valid) stale++;
    end
    chk_cnt++;
    if (stale !== 0) $display("[TB] FAIL stale_output: got %0d valid cycles, want 0", stale);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [6:0] opcs [14] = '{7'h03, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17,
                              7'h6F, 7'h67, 7'h73, 7'h33, 7'h3B, 7'h0F, 7'h7F};
    logic [31:0] r;
    int cyc = 0, outs = 0;
    exp_t e;
    sb.delete();
    while (cyc < 300) begin
      r = $urandom();
      if (cyc < 280) applyStimulus(($urandom_range(0, 3) != 0), {r[31:7], opcs[$urandom_range(0, 13)]}, 8'(cyc));
      else applyStimulus(1'b0, 32'd0, 8'd0);
      bus32.out_ready = (cyc >= 280) || ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (bus32.out_valid && bus32.out_ready) begin
        chk_cnt++; outs++;
        if (sb.size() == 0) $display("[TB] FAIL random: unexpected output tag=%h", bus32.out_tag);
        else begin
          e = sb.pop_front();
          if ({bus32.out_imm, bus32.out_fmt, bus32.out_illegal, bus32.out_tag} !== {e.imm[31:0], e.fmt, e.ill, e.tag})
            $display("[TB] FAIL random: got imm=%h fmt=%0d ill=%b tag=%h, want imm=%h fmt=%0d ill=%b tag=%h",
                     bus32.out_imm, bus32.out_fmt, bus32.out_illegal, bus32.out_tag,
                     e.imm[31:0], e.fmt, e.ill, e.tag);
          else pass_cnt++;
        end
      end
      if (bus32.in_valid && bus32.in_ready) begin
        model(bus32.in_instr, 1'b0, e.imm, e.fmt, e.ill);
        e.tag = bus32.in_tag; e.cyc = cyc;
        sb.push_back(e);
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk_cnt++;
    if (sb.size() !== 0 || outs == 0) $display("[TB] FAIL random_drain: got %0d pending %0d outputs, want 0 pending", sb.size(), outs);
    else pass_cnt++;
  endtask

`ifdef IMM_GEN_STATS_EN
  task automatic test_stats;
    logic [31:0] acc0, ill0;
    acc0 = acc32; ill0 = ill32;
    bus32.out_ready = 1'b1;
    applyStimulus(1'b1, 32'h0000007F, 8'h77);
    @(posedge clk); #1;
    applyStimulus(1'b1, 32'hFFF00093, 8'h78);
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'd0, 8'd0);
    repeat (2) @(posedge clk); #1;
    chk_cnt++;
    if ({acc32, ill32} !== {acc0 + 32'd2, ill0 + 32'd1})
      $display("[TB] FAIL stats: got acc=%0d ill=%0d, want acc=%0d ill=%0d", acc32, ill32, acc0 + 2, ill0 + 1);
    else pass_cnt++;
  endtask
`endif

  initial begin
    pass_cnt = 0;
    chk_cnt  = 0;
    test_reset();
    test_directed();
    test_xlen64();
    test_backpressure();
    test_reset_midstream();
    test_random();
`ifdef IMM_GEN_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate generator.
- Accepts one 32-bit instruction per cycle over a valid/ready handshake.
- Produces the XLEN-wide sign-extended immediate, a format code and an illegal-opcode flag one cycle later, with a 2-entry skid buffer for full-throughput backpressure.
- Sits between fetch and decode/execute in the pipelined core.

Parameters:
- XLEN, 32, datapath width; legal values 32 and 64.
- TAG_W, 8, width of the sideband tag (PC index, ROB id) carried alongside each instruction.

Ports:
- clk  input  1  core clock
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  instruction present
- in_ready  output  1  stage can accept
- in_instr  input  32  raw instruction
- in_tag  input  TAG_W  sideband, passed through unchanged
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts
- out_imm  output  XLEN  generated immediate
- out_fmt  output  3  format: 0 NONE/R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm)
- out_illegal  output  1  opcode not recognised
- out_tag  output  TAG_W  tag of the result

Behaviour:
- Reset:
  - Clearing is asynchronous on rst high.
  - out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, skid entry invalid, in_ready=1 from the first cycle after release.
  - Asserting rst mid-operation discards both buffered entries; no partial result is ever emitted.
- Handshake:
  - Transfer on in_valid&in_ready (input) or out_valid&out_ready (output).
  - out_* stay stable while out_valid=1 and out_ready=0.
- Latency and throughput:
  - 1 cycle from accept to out_valid.
  - 1 instruction/cycle when out_ready is held high.
- Skid buffer: output register plus one skid register.
  - in_ready = !skid_valid, registered, with no combinational path from out_ready.
  - Accept while output held: the result goes to skid.
  - Output drains: skid moves to output in the same cycle a new accept may enter skid.
  - Both full: in_ready=0.
- Simultaneous accept and drain with only the output register full: the new result replaces the output register directly. Skid stays empty.
- Decode (opcode = instr[6:0]):
  - I, for 0000011 LOAD, 0010011 OP-IMM, 1100111 JALR, and 0011011 OP-IMM-32 (legal only when XLEN=64): imm = sext(instr[31:20]).
  - S, for 0100011: imm = sext({instr[31:25], instr[11:7]}).
  - B, for 1100011: imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U, for 0110111 / 0010111: imm = sext({instr[31:12], 12'b0}). Upper bits are copies of instr[31] when XLEN=64.
  - J, for 1101111: imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - SYSTEM 1110011, funct3[2]=1: fmt Z, imm = zero-extended instr[19:15].
  - SYSTEM 1110011, funct3[2]=0: fmt I, imm = sext(instr[31:20]).
  - NONE with imm=0 and illegal=0, for 0110011, 0111011 (XLEN=64 only) and 0001111.
  - Any other opcode, including 0011011/0111011 when XLEN=32: imm=0, fmt=0, illegal=1.
- Sign extension always fills up to bit XLEN-1.
- in_instr and in_tag are sampled only on an input transfer. Values while in_valid=0 are ignored.

Optional Feature:
- Macro IMM_GEN_STATS_EN.
- When defined, adds output ports stat_acc_cnt[31:0] and stat_ill_cnt[31:0].
  - stat_acc_cnt counts input transfers.
  - stat_ill_cnt counts input transfers decoded illegal.
  - Both counters saturate at 0xFFFFFFFF and clear on rst.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package imm_gen_pkg holds:
  - opcode localparams: OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_SYSTEM, OPC_OP, OPC_OP32, OPC_FENCE
  - the 3-bit format enum imm_fmt_t (FMT_NONE..FMT_Z)
- One combinational sub-module, imm_decode_xlen, parametrised by XLEN: instr in, {imm, fmt, illegal} out.
- imm_gen_pipe instantiates imm_decode_xlen once and adds the skid/handshake logic.

Test Plan:
- XLEN=32, instruction 0xFFF00093 (addi x1,x0,-1), tag 0x5A, out_ready=1 -> next cycle out_imm=0xFFFFFFFF, fmt=1, illegal=0, tag=0x5A.
- Instruction 0xFE000EE3 (beq x0,x0,-4) -> out_imm=0xFFFFFFFC, fmt=3.
- U-type LUI:
  - XLEN=32, 0x123450B7 -> 0x12345000, fmt=4.
  - XLEN=64, 0x800000B7 -> 0xFFFFFFFF80000000.
- CSR zimm and illegal opcode:
  - 0x300FD073 (csrrwi x0,mstatus,31) -> imm=0x1F, fmt=6.
  - 0x0000007F -> imm=0, illegal=1. With IMM_GEN_STATS_EN, stat_ill_cnt increments by 1.
- Backpressure: stream 4 instructions back-to-back, drop out_ready for 3 cycles after the first output.
  - in_ready deasserts after 2 entries are held.
  - Results emerge in order with no loss or duplication.
  - out_* stay stable while stalled.
- Reset mid-stream: assert rst with both entries full.
  - out_valid=0 and in_ready=1 after release.
  - No stale result appears.
